// File: rtl/draw_cmd_scheduler_if.sv
// Handshake bundle between the register-side command source, the scheduler and drawunit.
// The scheduler is the slave: it receives pushes and answers drawunit's ack/done.
interface draw_cmd_scheduler_if;
  logic [7:0]   s_command;
  logic [255:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   m_command;
  logic [255:0] m_data;
  logic         m_commit;
  logic         m_ack;
  logic         m_done;

  modport slave (
    input  s_command, s_data, s_valid, m_ack, m_done,
    output s_ready, m_command, m_data, m_commit
  );

  modport master (
    output s_command, s_data, s_valid, m_ack, m_done,
    input  s_ready, m_command, m_data, m_commit
  );
endinterface

// File: rtl/draw_cmd_scheduler.sv
// Draw command queue: buffers RECT commands and issues them to drawunit one at a time
// over the commit/ack/done handshake; unsupported opcodes are dropped and flagged.
module draw_cmd_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  draw_cmd_scheduler_if.slave      bus,
  input  logic                     flush,
  input  logic                     clear_err,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic [CNT_W-1:0]         done_count,
  output logic                     err_bad_cmd
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [7:0]  OP_RECT = 8'h01;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RECOVER} state_e;

  state_e             state_q;
  logic [263:0]       mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q, level_d;
  logic [7:0]         cmd_q;
  logic [255:0]       data_q;
  logic               commit_q;
  logic [CNT_W-1:0]   done_cnt_q;
  logic               err_q;
  logic               full, push_acc, push_ok, push_bad, pop;

  assign full     = (level_q == LW'(DEPTH));
  assign push_acc = bus.s_valid && bus.s_ready;
  assign push_ok  = push_acc && (bus.s_command == OP_RECT);
  assign push_bad = push_acc && (bus.s_command != OP_RECT);
  // Flush suppresses the IDLE pop so a flushed head entry is never issued.
  assign pop      = (state_q == S_IDLE) && (level_q != '0) && !flush;

  assign bus.s_ready   = !full && !flush;
  assign bus.m_command = cmd_q;
  assign bus.m_data    = data_q;
  assign bus.m_commit  = commit_q;
  assign fifo_level    = level_q;
  assign busy          = (state_q != S_IDLE) || (level_q != '0);
  assign done_count    = done_cnt_q;
  assign err_bad_cmd   = err_q;

  always_comb begin
    level_d = level_q;
    if (flush)
      level_d = '0;
    else if (push_ok && !pop)
      level_d = level_q + 1'b1;
    else if (!push_ok && pop)
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= {bus.s_command, bus.s_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      commit_q   <= 1'b0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (flush)
        rd_ptr_q <= wr_ptr_q;
      else if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;

      if (push_bad)
        err_q <= 1'b1;
      else if (clear_err)
        err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            {cmd_q, data_q} <= mem_q[rd_ptr_q];
            commit_q        <= 1'b1;
            state_q         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.m_ack) begin
            commit_q <= 1'b0;
            if (bus.m_done) begin
              done_cnt_q <= done_cnt_q + 1'b1;
              state_q    <= S_RECOVER;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.m_done) begin
            done_cnt_q <= done_cnt_q + 1'b1;
            state_q    <= S_RECOVER;
          end
        end
        S_RECOVER: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Bench for draw_cmd_scheduler: drawunit model, issue-order scoreboard, error-flag vector table
// and directed sequences for stall/full, flush, ack+done and mid-command reset.
module tb_draw_cmd_scheduler;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic clear_err = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic busy;
  logic [CNT_W-1:0] done_count;
  logic err_bad_cmd;

  draw_cmd_scheduler_if bus ();

  draw_cmd_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .clear_err  (clear_err),
    .fifo_level (fifo_level),
    .busy       (busy),
    .done_count (done_count),
    .err_bad_cmd(err_bad_cmd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // drawunit model: ack ack_lat cycles after seeing commit, done done_lat cycles after ack
  int unsigned ack_lat = 1, done_lat = 1;
  bit du_stall = 1'b0, du_hold = 1'b0;
  int unsigned du_st, du_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.m_ack  <= 1'b0;
      bus.m_done <= 1'b0;
      du_st      <= 0;
      du_cnt     <= 0;
    end else begin
      bus.m_ack  <= 1'b0;
      bus.m_done <= 1'b0;
      case (du_st)
        0: if (bus.m_commit && !du_stall) begin du_cnt <= 1; du_st <= 1; end
        1: begin
          if (du_cnt >= ack_lat) begin
            bus.m_ack <= 1'b1;
            if (done_lat == 0) begin bus.m_done <= 1'b1; du_st <= 3; end
            else begin du_cnt <= 1; du_st <= 2; end
          end else du_cnt <= du_cnt + 1;
        end
        2: begin
          if (!du_hold && du_cnt >= done_lat) begin bus.m_done <= 1'b1; du_st <= 3; end
          else du_cnt <= du_cnt + 1;
        end
        default: du_st <= 0;
      endcase
    end
  end

  typedef struct packed {logic [7:0] cmd; logic [255:0] data;} cmd_t;
  cmd_t sbq[$];
  cmd_t sb_exp;

  always @(negedge clk) begin
    if (rst_n && bus.m_commit === 1'b1 && bus.m_ack === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_issue unexpected command act=%h", {bus.m_command, bus.m_data});
      end else begin
        sb_exp = sbq.pop_front();
        if ({bus.m_command, bus.m_data} !== sb_exp) begin
          bad++;
          $display("FAIL sb_issue act=%h exp=%h", {bus.m_command, bus.m_data}, sb_exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rect(input int x, input int y, input int w, input int h,
                                        input int color);
    logic [255:0] r;
    r = '0;
    r[9:0]   = x[9:0];
    r[19:10] = y[9:0];
    r[29:20] = w[9:0];
    r[39:30] = h[9:0];
    r[55:40] = color[15:0];
    return r;
  endfunction

  task automatic push(input logic [7:0] c, input logic [255:0] d, input logic exp_rdy,
                      input bit sb, input string nm);
    bus.s_valid = 1'b1;
    bus.s_command = c;
    bus.s_data = d;
    #1;
    chk(nm, 64'(bus.s_ready), 64'(exp_rdy));
    if (exp_rdy && c == 8'h01 && sb) sbq.push_back({c, d});
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [CNT_W-1:0] tgt, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clk); #1;
      if (done_count == tgt) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s timeout done_count=%0d want=%0d", nm, done_count, tgt);
    end
  endtask

  task automatic wait_commit(input logic val, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (bus.m_commit === val) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s timeout m_commit=%b want=%b", nm, bus.m_commit, val);
    end
  endtask

  typedef struct {logic v; logic [7:0] cmd; logic clr; logic exp_err;} vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{1'b1, 8'h07, 1'b0, 1'b1};
    vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1'b0};
    vt[3] = '{1'b1, 8'h07, 1'b1, 1'b1};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0};
    vt[5] = '{1'b1, 8'hFF, 1'b0, 1'b1};
    vt[6] = '{1'b1, 8'h00, 1'b1, 1'b1};
    vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0};

    bus.s_valid = 1'b0;
    bus.s_command = '0;
    bus.s_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_ready", 64'(bus.s_ready), 1);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_commit", 64'(bus.m_commit), 0);
    chk("rst_mcmd", 64'(bus.m_command), 0);
    chk("rst_mdata", bus.m_data[63:0], 0);
    chk("rst_done", 64'(done_count), 0);
    chk("rst_err", 64'(err_bad_cmd), 0);

    // single RECT: commit from t+1, ack seen at t+4, done_count at t+5
    push(8'h01, rect(10, 20, 4, 2, 'hF800), 1'b1, 1'b1, "t1_ready");
    chk("t1_level_t", 64'(fifo_level), 1);
    chk("t1_commit_t", 64'(bus.m_commit), 0);
    @(posedge clk); #1;
    chk("t1_commit_t1", 64'(bus.m_commit), 1);
    chk("t1_mcmd", 64'(bus.m_command), 1);
    chk("t1_mdata", bus.m_data[63:0], rect(10, 20, 4, 2, 'hF800) & 256'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_level_t1", 64'(fifo_level), 0);
    @(posedge clk); #1;
    chk("t1_commit_t2", 64'(bus.m_commit), 1);
    @(posedge clk); #1;
    chk("t1_commit_t3", 64'(bus.m_commit), 1);
    @(posedge clk); #1;
    chk("t1_commit_t4", 64'(bus.m_commit), 0);
    chk("t1_busy_wait", 64'(busy), 1);
    @(posedge clk); #1;
    chk("t1_done", 64'(done_count), 1);
    chk("t1_busy_rec", 64'(busy), 1);
    @(posedge clk); #1;
    chk("t1_busy_idle", 64'(busy), 0);

    // five back-to-back pushes against a stalled drawunit
    du_stall = 1'b1;
    for (int i = 0; i < 5; i++)
      push(8'h01, rect(100 + i, 200 + i, 8, 8, 'h07E0 + i), 1'b1, 1'b1, $sformatf("t2_push%0d", i));
    chk("t2_level_full", 64'(fifo_level), 4);
    chk("t2_ready_full", 64'(bus.s_ready), 0);
    push(8'h01, rect(1, 1, 1, 1, 'h1), 1'b0, 1'b1, "t2_push_full");
    chk("t2_level_held", 64'(fifo_level), 4);
    du_stall = 1'b0;
    wait_done(6, "t2_done");
    @(posedge clk); #1;
    chk("t2_level_end", 64'(fifo_level), 0);
    chk("t2_busy_end", 64'(busy), 0);

    // unsupported opcodes and err_bad_cmd set/clear priority
    foreach (vt[i]) begin
      bus.s_valid = vt[i].v;
      bus.s_command = vt[i].cmd;
      bus.s_data = '1;
      clear_err = vt[i].clr;
      #1;
      if (vt[i].v) chk($sformatf("vec%0d_ready", i), 64'(bus.s_ready), 1);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      clear_err = 1'b0;
      chk($sformatf("vec%0d_err", i), 64'(err_bad_cmd), 64'(vt[i].exp_err));
      chk($sformatf("vec%0d_level", i), 64'(fifo_level), 0);
      chk($sformatf("vec%0d_commit", i), 64'(bus.m_commit), 0);
    end

    // flush during WAIT: queued entries dropped, in-flight command completes
    du_hold = 1'b1;
    push(8'h01, rect(300, 301, 16, 16, 'hABCD), 1'b1, 1'b1, "t4_push");
    wait_commit(1'b1, "t4_commit_hi");
    wait_commit(1'b0, "t4_commit_lo");
    for (int i = 0; i < 3; i++)
      push(8'h01, rect(i, i, 2, 2, 'h55), 1'b1, 1'b0, $sformatf("t4_q%0d", i));
    chk("t4_level_q", 64'(fifo_level), 3);
    flush = 1'b1;
    #1;
    chk("t4_ready_flush", 64'(bus.s_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t4_level_flushed", 64'(fifo_level), 0);
    chk("t4_busy_wait", 64'(busy), 1);
    du_hold = 1'b0;
    wait_done(7, "t4_done");
    repeat (6) @(posedge clk);
    #1;
    chk("t4_commit_after", 64'(bus.m_commit), 0);
    chk("t4_busy_after", 64'(busy), 0);
    chk("t4_done_after", 64'(done_count), 7);

    // ack and done in the same cycle count once
    done_lat = 0;
    push(8'h01, rect(5, 6, 7, 8, 'h1234), 1'b1, 1'b1, "t5_push");
    wait_done(8, "t5_done");
    repeat (4) @(posedge clk);
    #1;
    chk("t5_done_once", 64'(done_count), 8);
    chk("t5_busy", 64'(busy), 0);
    done_lat = 1;

    // reset while waiting for done
    du_hold = 1'b1;
    push(8'h01, rect(9, 9, 9, 9, 'h9999), 1'b1, 1'b1, "t6_push");
    wait_commit(1'b1, "t6_commit_hi");
    wait_commit(1'b0, "t6_commit_lo");
    push(8'h01, rect(1, 2, 3, 4, 'h5), 1'b1, 1'b0, "t6_q0");
    push(8'h01, rect(4, 3, 2, 1, 'h6), 1'b1, 1'b0, "t6_q1");
    push(8'h07, '0, 1'b1, 1'b0, "t6_bad");
    chk("t6_err_pre", 64'(err_bad_cmd), 1);
    chk("t6_level_pre", 64'(fifo_level), 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_level", 64'(fifo_level), 0);
    chk("t6_rst_commit", 64'(bus.m_commit), 0);
    chk("t6_rst_mcmd", 64'(bus.m_command), 0);
    chk("t6_rst_mdata", 64'(|bus.m_data), 0);
    chk("t6_rst_done", 64'(done_count), 0);
    chk("t6_rst_err", 64'(err_bad_cmd), 0);
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_ready", 64'(bus.s_ready), 1);
    rst_n = 1'b1;
    du_hold = 1'b0;
    push(8'h01, rect(640, 480, 32, 32, 'hFFFF), 1'b1, 1'b1, "t6_push_after");
    wait_done(1, "t6_done_after");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
